// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies skip straight to DONE.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic [XLEN-1:0] op;
  logic [AW-1:0]   acc;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] res_pend;
  logic [XLEN-1:0] res_q;

  logic            is_div;
  logic            signed_a;
  logic            signed_b;
  logic            sa;
  logic            sb;
  logic            b_zero;
  logic            ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            accept;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic [AW-1:0]   acc_step;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fix_res;

  // Cycle-0 decode: signedness, magnitudes and fast-path detection
  always_comb begin : decode
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = signed_a & src_a[XLEN-1];
    sb       = signed_b & src_b[XLEN-1];
    mag_a    = sa ? -src_a : src_a;
    mag_b    = sb ? -src_b : src_b;
    b_zero   = (src_b == '0);
    ovf      = is_div && !funct3[0] && (src_a == SMIN) && (src_b == '1);
    fast     = 1'b0;
    fast_res = '0;
    if (is_div && b_zero) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? src_a : '1;
    end else if (ovf) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : SMIN;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && ((src_a == '0) || (src_b == '0))) begin
      fast     = 1'b1;
      fast_res = '0;
    end
`endif
  end

  // One iteration: acc = {hi, lo}; mul adds into hi and shifts right, div shifts left and trial-subtracts
  always_comb begin : iterate
    mul_sum   = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, op} : '0);
    div_trial = {acc[AW-1:XLEN], acc[XLEN-1]} - {1'b0, op};
    acc_step  = acc;
    if (f3[2]) begin
      if (!div_trial[XLEN]) begin
        acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {acc[AW-2:XLEN], acc[XLEN-1], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and hi/lo select
  always_comb begin : fixup
    prod = neg_q ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[AW-1:XLEN];
    case (f3)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[AW-1:XLEN];
      3'b100, 3'b101:         fix_res = neg_q ? -quo : quo;
      default:                fix_res = neg_r ? -rem : rem;
    endcase
  end

  assign accept = (state == IDLE) && start && !flush;

  always_ff @(posedge clk) begin : state_reg
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and outputs; result bypasses the pending value in the done cycle so a flush there leaves it untouched
  always_comb begin : fsm
    state_n = state;
    stall   = 1'b0;
    done    = 1'b0;
    result  = res_q;
    case (state)
      IDLE: begin
        stall = start;
        if (accept) state_n = fast ? DONE : RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        stall   = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = !flush;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush && (state != IDLE)) state_n = IDLE;
    if (done) result = res_pend;
  end

  always_ff @(posedge clk) begin : datapath
    if (!reset) begin
      cnt      <= '0;
      f3       <= '0;
      op       <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_pend <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3    <= funct3;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= '0;
            op    <= is_div ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (fast) res_pend <= fast_res;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        FIX:  res_pend <= fix_res;
        DONE: if (!flush) res_q <= res_pend;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_result;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle in which done is expected, counting the start cycle as 0
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == SMIN && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return SMIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // One complete op; noise scrambles inputs while busy to prove they are ignored
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit noise, input string name);
    int lat;
    int got;
    int stall_bad;
    logic [31:0] res_at_done;
    lat = ref_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL %s cycle0_stall got %b want 1", name, stall);
    end
    got = 0; stall_bad = 0; res_at_done = 32'hx;
    for (int cyc = 1; cyc <= 40 && got == 0; cyc++) begin
      @(negedge clk);
      if (noise) begin
        start = 1'($urandom); funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done === 1'b1) begin
        got = cyc;
        res_at_done = result;
        if (stall !== 1'b0) stall_bad++;
      end else if (stall !== 1'b1) begin
        stall_bad++;
      end
    end
    start = 1'b0;
    tests++;
    if (got != lat) begin
      fails++; $display("FAIL %s latency f3=%0d a=%h b=%h got %0d want %0d", name, f, a, b, got, lat);
    end
    tests++;
    if (stall_bad != 0) begin
      fails++; $display("FAIL %s stall_shape bad_cycles got %0d want 0", name, stall_bad);
    end
    tests++;
    if (res_at_done !== exp) begin
      fails++; $display("FAIL %s result f3=%0d a=%h b=%h got %h want %h", name, f, a, b, res_at_done, exp);
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || stall !== 1'b0 || result !== exp) begin
      fails++;
      $display("FAIL %s after_done done=%b stall=%b result=%h want 0 0 %h", name, done, stall, result, exp);
    end
    last_result = exp;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL reset_state stall=%b done=%b result=%h want 0 0 0", stall, done, result);
    end
    reset = 1'b1;
    last_result = 32'd0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7xm3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_m1m1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0, "mulhsu_m1x2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0, "rem_m7_2");
    run_op(3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 0, "divu_by0");
    run_op(3'd7, 32'd5,        32'd0,        32'd5,         0, "remu_by0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 0, "rem_by0");
    run_op(3'd4, SMIN,         32'hFFFF_FFFF, SMIN,          0, "div_ovf");
    run_op(3'd6, SMIN,         32'hFFFF_FFFF, 32'd0,         0, "rem_ovf");
    run_op(3'd0, 32'd0,        32'd9,        32'd0,         0, "mul_0x9");
    run_op(3'd0, 32'd3,        32'd4,        32'd12,        0, "mul_3x4");
  endtask

  task automatic test_flush_run();
    logic [31:0] prev;
    int pulses;
    prev = last_result;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd4;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 10) flush = 1'b1;
      #1;
      if (done === 1'b1) pulses++;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== prev) begin
      fails++;
      $display("FAIL flush_run stall=%b done=%b result=%h want 0 0 %h", stall, done, result, prev);
    end
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, "after_flush");
    tests++;
    if (pulses != 0) begin
      fails++; $display("FAIL flush_run_done_pulses got %0d want 0", pulses);
    end
  endtask

  task automatic test_flush_idle();
    int bad;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; src_a = 32'd5; src_b = 32'd6;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL flush_idle_stall got %b want 1", stall);
    end
    bad = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      if (stall !== 1'b0 || done !== 1'b0 || result !== last_result) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL flush_idle_accepted bad_cycles got %0d want 0", bad);
    end
  endtask

  task automatic test_flush_done();
    logic [31:0] prev;
    prev = last_result;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; src_a = 32'd5; src_b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    #1;
    tests++;
    if (done !== 1'b0 || stall !== 1'b0 || result !== prev) begin
      fails++;
      $display("FAIL flush_done_cycle done=%b stall=%b result=%h want 0 0 %h", done, stall, result, prev);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++;
    if (done !== 1'b0 || result !== prev) begin
      fails++; $display("FAIL flush_done_after done=%b result=%h want 0 %h", done, result, prev);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; src_a = $urandom; src_b = $urandom | 32'd1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 20) begin reset = 1'b0; flush = 1'b1; end
    end
    @(negedge clk);
    reset = 1'b1; flush = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL reset_mid stall=%b done=%b result=%h want 0 0 0", stall, done, result);
    end
    pulses = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (done === 1'b1 || stall !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++; $display("FAIL reset_mid_activity got %0d want 0", pulses);
    end
    last_result = 32'd0;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, ref_result(f, a, b), bit'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd4, 32'd100, 32'd7, ref_result(3'd4, 32'd100, 32'd7), 1, "b2b_div");
    run_op(3'd5, 32'd9,   32'd0, ref_result(3'd5, 32'd9, 32'd0),   1, "b2b_fast");
    run_op(3'd1, SMIN,    SMIN,  ref_result(3'd1, SMIN, SMIN),     1, "b2b_mulh");
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1234, ref_result(3'd7, 32'hDEAD_BEEF, 32'h1234), 1, "b2b_remu");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_run();
    test_flush_idle();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
